// File: rtl/q_serial.sv
// Process-noise covariance Q = ((dx0^2 + dx1^2)/2) * I for a 2-state filter,
// computed with a single shared squarer over two cycles.
module q_serial #(
  parameter int N    = 20,
  parameter int FRAC = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] x00_now,
  input  logic signed [N-1:0] x01_now,
  input  logic signed [N-1:0] x00_prev,
  input  logic signed [N-1:0] x01_prev,
  output logic                done,
  output logic signed [N-1:0] Q11,
  output logic signed [N-1:0] Q12,
  output logic signed [N-1:0] Q21,
  output logic signed [N-1:0] Q22
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ0  = 2'd1,
    SQ1  = 2'd2
  } state_t;

  localparam int PW = 2 * N + 2;

  state_t                state_r, state_s;
  logic signed [N:0]     d0_r, d1_r;
  logic signed [PW-1:0]  acc_r;
  logic signed [N:0]     mul_op_s;
  logic signed [PW-1:0]  mul_ext_s;
  logic signed [PW-1:0]  mul_p_s;
  logic signed [PW-1:0]  sq_s;
  logic signed [PW-1:0]  sum_s;
  logic signed [PW-1:0]  half_s;
  logic signed [N:0]     dx0_s, dx1_s;

  // Clamp a wide signed value into the N-bit signed output range.
  function automatic logic signed [N-1:0] sat_n(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] max_v;
    logic signed [PW-1:0] min_v;
    max_v = $signed({{(N+3){1'b0}}, {(N-1){1'b1}}});
    min_v = $signed({{(N+3){1'b1}}, {(N-1){1'b0}}});
    if (v > max_v) begin
      sat_n = max_v[N-1:0];
    end else if (v < min_v) begin
      sat_n = min_v[N-1:0];
    end else begin
      sat_n = v[N-1:0];
    end
  endfunction

  // Widened deltas: N+1 bits so the subtraction cannot overflow.
  always_comb begin
    dx0_s = $signed({x00_now[N-1], x00_now}) - $signed({x00_prev[N-1], x00_prev});
    dx1_s = $signed({x01_now[N-1], x01_now}) - $signed({x01_prev[N-1], x01_prev});
  end

  // Shared squarer: d0 in SQ0, d1 otherwise; then the SQ1 sum/halve path.
  always_comb begin
    mul_op_s  = d1_r;
    if (state_r == SQ0) begin
      mul_op_s = d0_r;
    end else begin
      mul_op_s = d1_r;
    end
    mul_ext_s = {{(N+1){mul_op_s[N]}}, mul_op_s};
    mul_p_s   = mul_ext_s * mul_ext_s;
    sq_s      = mul_p_s >>> FRAC;
    sum_s     = acc_r + sq_s;
    half_s    = sum_s >>> 1;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SQ0;
        end else begin
          state_s = IDLE;
        end
      end
      SQ0:     state_s = SQ1;
      SQ1:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_r  <= '0;
      d1_r  <= '0;
      acc_r <= '0;
      done  <= 1'b0;
      Q11   <= '0;
      Q12   <= '0;
      Q21   <= '0;
      Q22   <= '0;
    end else begin
      done <= 1'b0;
      Q12  <= '0;
      Q21  <= '0;
      case (state_r)
        IDLE: begin
          if (start) begin
            d0_r <= dx0_s;
            d1_r <= dx1_s;
          end
        end
        SQ0: begin
          acc_r <= sq_s;
        end
        SQ1: begin
          Q11  <= sat_n(half_s);
          Q22  <= sat_n(half_s);
          done <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q_serial.sv
// Directed self-checking bench for q_serial: latency, squaring, truncation,
// saturation, busy-start rejection and mid-operation reset.
module tb_q_serial;

  localparam int N    = 20;
  localparam int FRAC = 10;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic signed [N-1:0] x00_now, x01_now, x00_prev, x01_prev;
  logic                done;
  logic signed [N-1:0] Q11, Q12, Q21, Q22;

  int tests_run  = 0;
  int tests_fail = 0;
  int cyc;

  q_serial #(.N(N), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x00_now(x00_now), .x01_now(x01_now),
    .x00_prev(x00_prev), .x01_prev(x01_prev),
    .done(done), .Q11(Q11), .Q12(Q12), .Q21(Q21), .Q22(Q22)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input longint n0, input longint n1, input longint p0, input longint p1);
    x00_now  = n0[N-1:0];
    x01_now  = n1[N-1:0];
    x00_prev = p0[N-1:0];
    x01_prev = p1[N-1:0];
  endtask

  // After the start edge: count cycles until done, bounded.
  task automatic wait_done(input string tag);
    cyc = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
    end
    chk({tag, "_done_seen"}, longint'(done), 1);
    chk({tag, "_latency"}, cyc, 3);
  endtask

  task automatic run_op(input string tag, input longint n0, input longint n1,
                        input longint p0, input longint p1, input longint exp_q);
    @(negedge clk);
    set_ops(n0, n1, p0, p1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(tag);
    chk({tag, "_q11"}, Q11, exp_q);
    chk({tag, "_q22"}, Q22, exp_q);
    chk({tag, "_q12"}, Q12, 0);
    chk({tag, "_q21"}, Q21, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, longint'(done), 0);
    chk({tag, "_q11_hold"}, Q11, exp_q);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_ops(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", longint'(done), 0);
    chk("rst_q11", Q11, 0);
    chk("rst_q12", Q12, 0);
    chk("rst_q21", Q21, 0);
    chk("rst_q22", Q22, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // dx=(2.0,1.0): (4+1)/2 = 2.5
    run_op("basic", 2048, 1024, 0, 0, 2560);
    // dx=0
    run_op("zero", 1536, -768, 1536, -768, 0);
    // dx=(-2.0,-1.0)
    run_op("neg", -1024, -512, 1024, 512, 2560);
    // truncation: (2025>>10)+(2116>>10) = 1+2 = 3, >>1 = 1
    run_op("trunc", -45, 46, 0, 0, 1);
    // dx=(200.0,200.0) saturates
    run_op("sat", 204800, 204800, 0, 0, 524287);
    // full-range deltas
    run_op("extreme", -524288, 524287, 524287, -524288, 524287);

    // Busy start during SQ0 with changed operands: ignored.
    @(negedge clk);
    set_ops(2048, 1024, 0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    set_ops(-45, 46, 0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 2;
    for (int i = 0; i < 10; i++) begin
      if (done) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk("busy_latency", cyc, 3);
    chk("busy_q11", Q11, 2560);
    repeat (3) begin
      @(posedge clk); #1;
      chk("busy_no_queue", longint'(done), 0);
    end
    run_op("busy_next", -45, 46, 0, 0, 1);

    // Set a nonzero result, then reset while in SQ1.
    run_op("pre_rst", 2048, 1024, 0, 0, 2560);
    @(negedge clk);
    set_ops(-1024, -512, 1024, 512);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_done", longint'(done), 0);
    chk("midrst_q11", Q11, 0);
    chk("midrst_q22", Q22, 0);
    @(posedge clk); #1;
    chk("midrst_done_hold", longint'(done), 0);
    chk("midrst_q11_hold", Q11, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_done", longint'(done), 0);
    run_op("post_rst", -1024, -512, 1024, 512, 2560);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule

// File: doc/q_serial.md
Name: q_serial

Overview:
- Computes a process-noise covariance matrix Q for a 2-state filter from the state increment dx = x_now - x_prev.
- Q = ((dx0^2 + dx1^2)/2) * I. Off-diagonal terms are zero.
- Uses one shared multiplier over two cycles and signals completion with a done pulse.
- Feeds the Q input of the Kalman predict stage.

Parameters:
- N, 20, total signed fixed-point word width of all data ports.
- FRAC, 10, fractional bits (Q(N-FRAC).FRAC format; 1.0 = 2^FRAC).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; operands sampled on the same edge.
- x00_now  in  N signed  current state element 0.
- x01_now  in  N signed  current state element 1.
- x00_prev  in  N signed  previous state element 0.
- x01_prev  in  N signed  previous state element 1.
- done  out  1  one-cycle pulse; Q outputs are valid from this cycle onward.
- Q11  out  N signed  diagonal term (0,0).
- Q12  out  N signed  off-diagonal term, always 0.
- Q21  out  N signed  off-diagonal term, always 0.
- Q22  out  N signed  diagonal term (1,1), equal to Q11.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: FSM = IDLE; done=0; Q11=Q12=Q21=Q22=0; all internal registers cleared.
- FSM states: IDLE -> SQ0 -> SQ1 -> IDLE.
- IDLE: when start=1 at edge k:
  - register d0 = x00_now - x00_prev and d1 = x01_now - x01_prev, each N+1 bits signed (no overflow);
  - go to SQ0.
- SQ0 (edge k+1):
  - p0 = (d0*d0) >>> FRAC using the shared multiplier (2N+2 bits);
  - store in accumulator acc, then go to SQ1.
- SQ1 (edge k+2):
  - acc + ((d1*d1) >>> FRAC), then >>> 1 (divide by 2, truncating);
  - saturate to N-bit signed [-(2^(N-1)), 2^(N-1)-1]. The result is non-negative, so only the positive clamp is active;
  - register the result into Q11 and Q22; Q12=Q21=0;
  - done=1; return to IDLE.
- Latency: start sampled at edge k -> done high after edge k+2, low after edge k+3.
  - A cycle counter set to 1 on the start edge and incremented while done=0 reads 3 when done is observed.
- done is high for exactly one cycle per start.
- Q outputs hold their value until the next completed computation.
- start while busy (SQ0/SQ1): ignored, with no restart and no queueing.
- start held high for multiple cycles: a new computation begins on the first IDLE cycle it is sampled high.
- Inputs are sampled only on the start edge; later changes do not affect the current result.
- Rounding: all shifts are arithmetic truncation toward minus infinity. No rounding offset is added.
- dx = 0: Q11=Q22=0, and done still pulses at k+2.
- Reset mid-operation: immediate return to IDLE, with outputs and done cleared.

Test Plan:
- prev=(0,0), now=(2.0,1.0) i.e. (2048,1024) with FRAC=10: start pulse -> done at cycle 3, Q11=Q22=2560 (2.5), Q12=Q21=0.
- now=prev=(1.5,-0.75) -> Q11=Q22=0, done still pulses once at cycle 3.
- prev=(1.0,0.5), now=(-1.0,-0.5) i.e. dx=(-2.0,-1.0) -> Q11=Q22=2560; checks that negative deltas square correctly.
- dx=(200.0,200.0) -> exact result exceeds 2^(N-1)-1, so Q11=Q22=524287 (saturated).
- start re-pulsed during SQ0, with inputs changed after the first start -> single done, result from the first operands; the next start after IDLE computes the new operands.
- rst_n asserted in SQ1 -> done stays 0, outputs 0; a subsequent start works normally with 3-cycle latency.
